// File: rtl/jtag_ahb_master.sv
// jtag_ahb_master
//   Single-transfer AHB-Lite master for the JTAG AHB data register. A request
//   held on ahb_enable becomes one NONSEQ transfer. When the data phase ends the
//   block raises a one-cycle ack, then waits for the requester to drop
//   ahb_enable before it will take another request.
// Ports
//   CLK, nRST                    clock, async active-low reset
//   ahb_enable                   request level (held until after ack)
//   req_addr/wdata/write/size    transfer descriptor, latched in IDLE
//   ack                          one-cycle completion pulse
//   rdata                        last successful read data
//   resp_err                     last transfer ended in ERROR or timeout
//   busy                         state != IDLE
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   AHB-Lite master outputs
//   HRDATA/HREADY/HRESP          AHB-Lite slave responses
module jtag_ahb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ahb_enable,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ACK, S_HOLD
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_haddr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [1:0]        r_htrans;
  logic              r_ack;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata;
  logic              r_resp_err;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_start;
  logic       w_done_ok;
  logic       w_done_err;
  logic       w_tmo;
  logic [1:0] w_htrans_nxt;
  logic       w_ack_nxt;
  logic       w_busy_nxt;

  assign w_start    = (r_state == S_IDLE) && ahb_enable;
  assign w_done_ok  = (r_state == S_DATA) && HREADY && !HRESP;
  assign w_done_err = (r_state == S_DATA) && HREADY && HRESP;
  // Wait-state cycle that would be the TIMEOUT-th: give up on the slave.
  assign w_tmo      = (r_state == S_DATA) && !HREADY &&
                      (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ahb_enable)          w_state_nxt = S_ADDR;
      S_ADDR: if (HREADY)              w_state_nxt = S_DATA;
      S_DATA: if (HREADY || w_tmo)     w_state_nxt = S_ACK;
      S_ACK:                           w_state_nxt = S_HOLD;
      // Enable is still high for a cycle after ack; do not re-trigger on it.
      S_HOLD: if (!ahb_enable)         w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    w_htrans_nxt = HT_IDLE;
    w_ack_nxt    = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_ADDR:  w_htrans_nxt = HT_NONSEQ;
      S_ACK:   w_ack_nxt    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_htrans <= HT_IDLE;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_htrans <= w_htrans_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Request latch: address-phase signals double as the held descriptor.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_wdata  <= '0;
    end else if (w_start) begin
      r_haddr  <= req_addr;
      r_hwrite <= req_write;
      r_hsize  <= req_size;
      r_wdata  <= req_wdata;
    end
  end

  // Write data presented for the data phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                 r_hwdata <= '0;
    else if ((r_state == S_ADDR) && HREADY)    r_hwdata <= r_wdata;
  end

  // Wait-state counter, cleared on entry to DATA.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                 r_cnt <= '0;
    else if ((r_state == S_ADDR) && HREADY)    r_cnt <= '0;
    else if ((r_state == S_DATA) && !HREADY)   r_cnt <= r_cnt + CNT_W'(1);
  end

  // Completion status. rdata only moves on a clean read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_done_ok) begin
        r_resp_err <= 1'b0;
        if (!r_hwrite) r_rdata <= HRDATA;
      end else if (w_done_err || w_tmo) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  assign HADDR    = r_haddr;
  assign HTRANS   = r_htrans;
  assign HWRITE   = r_hwrite;
  assign HSIZE    = r_hsize;
  assign HWDATA   = r_hwdata;
  assign ack      = r_ack;
  assign busy     = r_busy;
  assign rdata    = r_rdata;
  assign resp_err = r_resp_err;

endmodule

// File: tb/tb_jtag_ahb_master.sv
module tb_jtag_ahb_master;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ahb_enable;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [2:0]  req_size;
  logic        ack;
  logic [31:0] rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  jtag_ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .ahb_enable(ahb_enable), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .ack(ack), .rdata(rdata), .resp_err(resp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got=%h exp=%h", HTRANS, 2'b00); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr got=%h exp=%h", HADDR, 32'h0); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata got=%h exp=%h", HWDATA, 32'h0); end
    checks++; if ({HWRITE, HSIZE} !== 4'h0) begin errors++; $display("FAIL rst_hwrite_hsize got=%h exp=%h", {HWRITE, HSIZE}, 4'h0); end
    checks++; if ({ack, busy, resp_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=%b", {ack, busy, resp_err}, 3'b000); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=%h", rdata, 32'h0); end
  endtask

  // Zero-wait read: NONSEQ at cycle 1, ack at cycle 3.
  task automatic test_read_ok();
    ahb_enable = 1; req_addr = 32'h2000_0010; req_write = 0; req_size = 3'd2;
    HREADY = 1; HRESP = 0; HRDATA = 32'h0;
    step(); // c1
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rd_htrans_c1 got=%h exp=%h", HTRANS, 2'b10); end
    checks++; if (HADDR !== 32'h2000_0010) begin errors++; $display("FAIL rd_haddr got=%h exp=%h", HADDR, 32'h2000_0010); end
    checks++; if ({HWRITE, HSIZE, busy} !== 5'b0_010_1) begin errors++; $display("FAIL rd_ctl got=%b exp=%b", {HWRITE, HSIZE, busy}, 5'b0_010_1); end
    req_addr = 32'hFFFF_FFFF; // must be ignored outside IDLE
    step(); // c2
    checks++; if ({HTRANS, ack} !== 3'b000) begin errors++; $display("FAIL rd_data_c2 got=%b exp=%b", {HTRANS, ack}, 3'b000); end
    checks++; if (HADDR !== 32'h2000_0010) begin errors++; $display("FAIL rd_haddr_hold got=%h exp=%h", HADDR, 32'h2000_0010); end
    HRDATA = 32'hDEAD_BEEF;
    step(); // c3
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c3 got=%b exp=%b", ack, 1'b1); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=%b", resp_err, 1'b0); end
    ahb_enable = 0; HRDATA = 32'h0;
    step(); // c4 HOLD
    checks++; if ({ack, busy} !== 2'b01) begin errors++; $display("FAIL rd_hold got=%b exp=%b", {ack, busy}, 2'b01); end
    step(); // c5 IDLE
    checks++; if ({busy, HTRANS} !== 3'b000) begin errors++; $display("FAIL rd_idle got=%b exp=%b", {busy, HTRANS}, 3'b000); end
  endtask

  // Write with 3 wait states: ack at cycle 6.
  task automatic test_write_wait();
    ahb_enable = 1; req_addr = 32'h4000_0000; req_wdata = 32'h1234_5678;
    req_write = 1; req_size = 3'd2; HREADY = 1; HRESP = 0; HRDATA = 32'h0;
    step(); // c1
    checks++; if ({HTRANS, HWRITE} !== 3'b101) begin errors++; $display("FAIL wr_addr got=%b exp=%b", {HTRANS, HWRITE}, 3'b101); end
    req_wdata = 32'hAAAA_AAAA; // late change must not reach HWDATA
    for (int c = 2; c <= 5; c++) begin
      step();
      HREADY = (c == 5);
      checks++; if (HWDATA !== 32'h1234_5678) begin errors++; $display("FAIL wr_hwdata_c%0d got=%h exp=%h", c, HWDATA, 32'h1234_5678); end
      checks++; if ({HTRANS, ack} !== 3'b000) begin errors++; $display("FAIL wr_data_c%0d got=%b exp=%b", c, {HTRANS, ack}, 3'b000); end
    end
    step(); // c6
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack_c6 got=%b exp=%b", ack, 1'b1); end
    checks++; if ({rdata, resp_err} !== {32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL wr_status got=%h exp=%h", {rdata, resp_err}, {32'hDEAD_BEEF, 1'b0}); end
    ahb_enable = 0;
    step(); step();
  endtask

  // Two-cycle ERROR on a read.
  task automatic test_error();
    ahb_enable = 1; req_addr = 32'h2000_0020; req_write = 0; HREADY = 1; HRESP = 0;
    step(); // c1
    step(); // c2
    HREADY = 0; HRESP = 1;
    step(); // c3
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL err_noack_c3 got=%b exp=%b", ack, 1'b0); end
    HREADY = 1; HRESP = 1; HRDATA = 32'hBAD0_BAD0;
    step(); // c4
    checks++; if ({ack, resp_err} !== 2'b11) begin errors++; $display("FAIL err_ack got=%b exp=%b", {ack, resp_err}, 2'b11); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_rdata got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    ahb_enable = 0; HRESP = 0;
    step(); // c5
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL err_single_ack got=%b exp=%b", ack, 1'b0); end
    step();
  endtask

  // ADDR wait state, then enable held high past ack.
  task automatic test_hold_stale();
    ahb_enable = 1; req_addr = 32'h2000_0030; req_write = 0; HREADY = 0; HRESP = 0;
    step(); // c1
    step(); // c2: still in ADDR
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h2000_0030}) begin errors++; $display("FAIL hs_addr_wait got=%h exp=%h", {HTRANS, HADDR}, {2'b10, 32'h2000_0030}); end
    HREADY = 1;
    step(); // c3 DATA
    HRDATA = 32'h55AA_55AA;
    step(); // c4
    checks++; if ({ack, resp_err} !== 2'b10) begin errors++; $display("FAIL hs_ack got=%b exp=%b", {ack, resp_err}, 2'b10); end
    checks++; if (rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL hs_rdata got=%h exp=%h", rdata, 32'h55AA_55AA); end
    step(); // c5 HOLD, enable still high
    checks++; if ({HTRANS, busy, ack} !== 4'b0010) begin errors++; $display("FAIL hs_hold_c5 got=%b exp=%b", {HTRANS, busy, ack}, 4'b0010); end
    step(); // c6 still HOLD
    checks++; if ({HTRANS, busy} !== 3'b001) begin errors++; $display("FAIL hs_hold_c6 got=%b exp=%b", {HTRANS, busy}, 3'b001); end
    ahb_enable = 0;
    step(); // c7
    checks++; if ({HTRANS, busy} !== 3'b000) begin errors++; $display("FAIL hs_idle got=%b exp=%b", {HTRANS, busy}, 3'b000); end
  endtask

  // HREADY stuck low, TIMEOUT=8: ack at cycle 10.
  task automatic test_timeout();
    ahb_enable = 1; req_addr = 32'h2000_0040; req_write = 0; HREADY = 1; HRESP = 0;
    step(); // c1
    step(); // c2
    HREADY = 0;
    for (int c = 2; c <= 9; c++) begin
      if (c > 2) step();
      checks++; if ({ack, busy} !== 2'b01) begin errors++; $display("FAIL to_wait_c%0d got=%b exp=%b", c, {ack, busy}, 2'b01); end
    end
    step(); // c10
    checks++; if ({ack, resp_err} !== 2'b11) begin errors++; $display("FAIL to_ack got=%b exp=%b", {ack, resp_err}, 2'b11); end
    checks++; if (rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL to_rdata got=%h exp=%h", rdata, 32'h55AA_55AA); end
    ahb_enable = 0; HREADY = 1; HRDATA = 32'h0BAD_0BAD;
    step(); // c11
    checks++; if ({ack, busy} !== 2'b01) begin errors++; $display("FAIL to_hold got=%b exp=%b", {ack, busy}, 2'b01); end
    step(); // c12
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_drop got=%b exp=%b", busy, 1'b0); end
    checks++; if ({rdata, resp_err} !== {32'h55AA_55AA, 1'b1}) begin errors++; $display("FAIL to_status_hold got=%h exp=%h", {rdata, resp_err}, {32'h55AA_55AA, 1'b1}); end
  endtask

  // Reset during DATA, then a fresh read.
  task automatic test_reset_mid();
    ahb_enable = 1; req_addr = 32'h2000_0050; req_write = 0; HREADY = 1; HRESP = 0;
    step(); // c1
    step(); // c2 DATA
    HREADY = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre got=%b exp=%b", busy, 1'b1); end
    nRST = 0;
    #1;
    checks++; if ({HTRANS, busy, ack, resp_err} !== 5'b00000) begin errors++; $display("FAIL rm_flags got=%b exp=%b", {HTRANS, busy, ack, resp_err}, 5'b00000); end
    checks++; if ({HADDR, rdata} !== 64'h0) begin errors++; $display("FAIL rm_regs got=%h exp=%h", {HADDR, rdata}, 64'h0); end
    @(negedge CLK);
    step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_noack got=%b exp=%b", ack, 1'b0); end
    nRST = 1; req_addr = 32'h3000_0004; HREADY = 1;
    step(); // c1
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h3000_0004}) begin errors++; $display("FAIL rm_new_addr got=%h exp=%h", {HTRANS, HADDR}, {2'b10, 32'h3000_0004}); end
    step(); // c2
    HRDATA = 32'hCAFE_F00D;
    step(); // c3
    checks++; if ({ack, resp_err} !== 2'b10) begin errors++; $display("FAIL rm_new_ack got=%b exp=%b", {ack, resp_err}, 2'b10); end
    checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_new_rdata got=%h exp=%h", rdata, 32'hCAFE_F00D); end
    ahb_enable = 0;
    step(); step();
  endtask

  initial begin
    nRST = 0; ahb_enable = 0; req_addr = '0; req_wdata = '0; req_write = 0;
    req_size = '0; HRDATA = '0; HREADY = 1; HRESP = 0;
    @(negedge CLK); @(negedge CLK);
    test_reset();
    nRST = 1;
    @(negedge CLK);
    test_read_ok();
    test_write_wait();
    test_error();
    test_hold_stale();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
